counter_updown_mod: RTL and testbench

//   Parametrised successor to the 3-bit counter: up/down modulo-N counter with

---
 rtl/counter_updown_mod.sv | 110 +++++++++++
 tb/tb_counter_updown_mod.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_updown_mod.sv
// counter_updown_mod: parametrised up/down modulo-N counter.
//   Supports synchronous clear and load (clamped to MAX), and a count enable.
//   OV and UF are registered one-cycle pulses.
//   TC is the combinational terminal-count flag.
// Parameters:
//   WIDTH  - counter width in bits (1..32)
//   MODULO - count modulus (2..2**WIDTH); MAX = MODULO-1
// Configuration macro:
//   COUNTER_UPDOWN_SAT_EN - when defined, the counter saturates at 0 and MAX
//   instead of wrapping. OV/UF still pulse on each blocked step.
// Ports:
//   clk      in  rising-edge clock
//   Reset    in  synchronous active-high reset
//   EN       in  count enable
//   CLR      in  synchronous clear to 0
//   UP       in  direction (1 = up, 0 = down)
//   LOAD     in  synchronous load of load_val
//   load_val in  [WIDTH] value to load
//   counter  out [WIDTH] registered count
//   OV       out registered overflow pulse
//   UF       out registered underflow pulse
//   TC       out combinational terminal count
module counter_updown_mod #(
    parameter int unsigned      WIDTH  = 3,
    parameter longint unsigned  MODULO = 8
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             EN,
    input  logic             CLR,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] counter,
    output logic             OV,
    output logic             UF,
    output logic             TC
);

    // One extra bit so MAX and increments never alias when MODULO == 2**WIDTH.
    localparam int unsigned     XW    = WIDTH + 1;
    localparam logic [XW-1:0]   MAX_X = XW'(MODULO - 64'd1);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MODULO - 64'd1);

    logic [XW-1:0]    cnt_x;
    logic [XW-1:0]    load_x;
    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] cnt_nxt;
    logic             ov_nxt;
    logic             uf_nxt;

    assign cnt_x   = {1'b0, counter};
    assign load_x  = {1'b0, load_val};
    assign at_max  = (cnt_x == MAX_X);
    assign at_zero = (counter == '0);

    // Terminal count follows the current count and direction with no delay.
    assign TC = UP ? at_max : at_zero;

    // Next-state selection: CLR > LOAD > EN > hold.
    always_comb begin
        cnt_nxt = counter;
        ov_nxt  = 1'b0;
        uf_nxt  = 1'b0;
        if (CLR) begin
            cnt_nxt = '0;
        end else if (LOAD) begin
            cnt_nxt = (load_x > MAX_X) ? MAX_W : load_val;
        end else if (EN) begin
            if (UP) begin
                if (at_max) begin
`ifdef COUNTER_UPDOWN_SAT_EN
                    cnt_nxt = MAX_W;
`else
                    cnt_nxt = '0;
`endif
                    ov_nxt  = 1'b1;
                end else begin
                    cnt_nxt = WIDTH'(cnt_x + XW'(1));
                end
            end else begin
                if (at_zero) begin
`ifdef COUNTER_UPDOWN_SAT_EN
                    cnt_nxt = '0;
`else
                    cnt_nxt = MAX_W;
`endif
                    uf_nxt  = 1'b1;
                end else begin
                    cnt_nxt = WIDTH'(cnt_x - XW'(1));
                end
            end
        end
    end

    // Count and pulse registers; reset overrides every other control.
    always_ff @(posedge clk) begin
        if (Reset) begin
            counter <= '0;
            OV      <= 1'b0;
            UF      <= 1'b0;
        end else begin
            counter <= cnt_nxt;
            OV      <= ov_nxt;
            UF      <= uf_nxt;
        end
    end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed and random checks for counter_updown_mod.
// Instance a uses WIDTH=3, MODULO=6; instance b uses WIDTH=4, MODULO=16.
module tb_counter_updown_mod;

`ifdef COUNTER_UPDOWN_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam int MAX_A = 5;
    localparam int MAX_B = 15;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1, en_a = 1'b0, clr_a = 1'b0, up_a = 1'b1, ld_a = 1'b0;
    logic [2:0] lv_a  = '0;
    logic [2:0] cnt_a;
    logic       ov_a, uf_a, tc_a;

    logic       rst_b = 1'b1, en_b = 1'b0, clr_b = 1'b0, up_b = 1'b1, ld_b = 1'b0;
    logic [3:0] lv_b  = '0;
    logic [3:0] cnt_b;
    logic       ov_b, uf_b, tc_b;

    counter_updown_mod #(.WIDTH(3), .MODULO(6)) u_dut_a (
        .clk(clk), .Reset(rst_a), .EN(en_a), .CLR(clr_a), .UP(up_a), .LOAD(ld_a),
        .load_val(lv_a), .counter(cnt_a), .OV(ov_a), .UF(uf_a), .TC(tc_a)
    );

    counter_updown_mod #(.WIDTH(4), .MODULO(16)) u_dut_b (
        .clk(clk), .Reset(rst_b), .EN(en_b), .CLR(clr_b), .UP(up_b), .LOAD(ld_b),
        .load_val(lv_b), .counter(cnt_b), .OV(ov_b), .UF(uf_b), .TC(tc_b)
    );

    typedef struct {
        string tag;
        int    cnt;
        bit    ov;
        bit    uf;
    } exp_t;

    exp_t  sb_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    m_cnt_a = 0, m_cnt_b = 0;
    bit    valid_a = 1'b0, valid_b = 1'b0;
    string cur_tag = "init";

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Reference behaviour of one counter step.
    function automatic void model_step(input int max, input bit r, input bit c, input bit l,
                                       input bit e, input bit u, input int lv,
                                       inout int cnt, output bit ov, output bit uf);
        ov = 1'b0;
        uf = 1'b0;
        if (r)      cnt = 0;
        else if (c) cnt = 0;
        else if (l) cnt = (lv > max) ? max : lv;
        else if (e) begin
            if (u) begin
                if (cnt == max) begin ov = 1'b1; cnt = SAT ? max : 0; end
                else cnt = cnt + 1;
            end else begin
                if (cnt == 0) begin uf = 1'b1; cnt = SAT ? 0 : max; end
                else cnt = cnt - 1;
            end
        end
    endfunction

    // One clock: check TC, push expected results, clock, pop and compare.
    task automatic tick();
        exp_t ea, eb, ga, gb;
        bit   ov, uf;
        #1;
        if (valid_a) check({cur_tag, ".a.tc"}, 32'(tc_a),
                           32'(up_a ? (m_cnt_a == MAX_A) : (m_cnt_a == 0)));
        if (valid_b) check({cur_tag, ".b.tc"}, 32'(tc_b),
                           32'(up_b ? (m_cnt_b == MAX_B) : (m_cnt_b == 0)));
        model_step(MAX_A, rst_a, clr_a, ld_a, en_a, up_a, int'(lv_a), m_cnt_a, ov, uf);
        ea = '{tag: {cur_tag, ".a"}, cnt: m_cnt_a, ov: ov, uf: uf};
        sb_q.push_back(ea);
        model_step(MAX_B, rst_b, clr_b, ld_b, en_b, up_b, int'(lv_b), m_cnt_b, ov, uf);
        eb = '{tag: {cur_tag, ".b"}, cnt: m_cnt_b, ov: ov, uf: uf};
        sb_q.push_back(eb);
        if (rst_a) valid_a = 1'b1;
        if (rst_b) valid_b = 1'b1;
        @(posedge clk);
        #1;
        ga = sb_q.pop_front();
        if (valid_a) begin
            check({ga.tag, ".cnt"}, 32'(cnt_a), 32'(ga.cnt));
            check({ga.tag, ".ov"},  32'(ov_a),  32'(ga.ov));
            check({ga.tag, ".uf"},  32'(uf_a),  32'(ga.uf));
        end
        gb = sb_q.pop_front();
        if (valid_b) begin
            check({gb.tag, ".cnt"}, 32'(cnt_b), 32'(gb.cnt));
            check({gb.tag, ".ov"},  32'(ov_b),  32'(gb.ov));
            check({gb.tag, ".uf"},  32'(uf_b),  32'(gb.uf));
        end
    endtask

    task automatic set_a(input bit r, input bit e, input bit c, input bit u,
                         input bit l, input int lv);
        rst_a = r; en_a = e; clr_a = c; up_a = u; ld_a = l; lv_a = 3'(lv);
    endtask

    task automatic set_b(input bit r, input bit e, input bit c, input bit u,
                         input bit l, input int lv);
        rst_b = r; en_b = e; clr_b = c; up_b = u; ld_b = l; lv_b = 4'(lv);
    endtask

    initial begin
        // Both counters held in reset for two cycles.
        cur_tag = "reset";
        set_a(1, 0, 0, 1, 0, 0);
        set_b(1, 0, 0, 1, 0, 0);
        tick();
        tick();
        set_b(0, 0, 0, 1, 0, 0);

        // Count up through the wrap: 1,2,3,4,5,0(OV),1.
        cur_tag = "up_wrap";
        set_a(0, 1, 0, 1, 0, 0);
        repeat (7) tick();

        // Load 2 then count down: 2,1,0,5(UF),4.
        cur_tag = "load_down";
        set_a(0, 0, 0, 0, 1, 2);
        tick();
        set_a(0, 1, 0, 0, 0, 0);
        repeat (4) tick();

        // Hold with EN low.
        cur_tag = "hold";
        set_a(0, 0, 0, 1, 0, 0);
        repeat (2) tick();

        // Clamped load, load beats enable, clear beats load.
        cur_tag = "load_clamp";
        set_a(0, 0, 0, 1, 1, 7);
        tick();
        cur_tag = "load_en";
        set_a(0, 1, 0, 1, 1, 3);
        tick();
        cur_tag = "clr_load";
        set_a(0, 1, 1, 1, 1, 4);
        tick();

        // Reset mid-count at 4, then resume from 0.
        cur_tag = "mid_reset";
        set_a(0, 1, 0, 1, 0, 0);
        repeat (4) tick();
        set_a(1, 1, 0, 1, 1, 2);
        tick();
        set_a(0, 1, 0, 1, 0, 0);
        repeat (2) tick();

        // Saturation-relevant bounds: up from 4 past MAX, down from 1 past 0.
        cur_tag = "bound_up";
        set_a(0, 0, 0, 1, 1, 4);
        tick();
        set_a(0, 1, 0, 1, 0, 0);
        repeat (4) tick();
        cur_tag = "bound_down";
        set_a(0, 0, 0, 0, 1, 1);
        tick();
        set_a(0, 1, 0, 0, 0, 0);
        repeat (3) tick();

        // Full-range instance: wrap from 15, hold, then underflow.
        cur_tag = "w4_wrap";
        set_a(0, 0, 0, 1, 0, 0);
        set_b(0, 0, 0, 1, 1, 15);
        tick();
        set_b(0, 1, 0, 1, 0, 0);
        tick();
        cur_tag = "w4_hold";
        set_b(0, 0, 0, 1, 0, 0);
        repeat (2) tick();
        cur_tag = "w4_under";
        set_b(0, 1, 0, 0, 0, 0);
        repeat (2) tick();

        // Random controls with direction changing every cycle.
        cur_tag = "random";
        for (int i = 0; i < 60; i++) begin
            set_a($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 14) == 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 7) == 0, int'($urandom_range(0, 7)));
            set_b($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 14) == 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 7) == 0, int'($urandom_range(0, 15)));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
